// File: rtl/uart_pkg.sv
// Shared UART definitions: character and receive-FIFO entry layout, plus a constant clog2 helper.
package uart_pkg;

    localparam int unsigned UART_DATA_W  = 8;
    localparam int unsigned RXF_ENTRY_W  = 10;
    localparam int unsigned RXF_DATA_LSB = 0;
    localparam int unsigned RXF_PERR_BIT = 8;
    localparam int unsigned RXF_FERR_BIT = 9;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port entry storage: synchronous write, asynchronous read.
// Isolated so a technology RAM can replace it without touching the FIFO control.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_wr_en,
    input  logic [AW-1:0]          i_wr_addr,
    input  logic [RXF_ENTRY_W-1:0] i_wr_data,
    input  logic [AW-1:0]          i_rd_addr,
    output logic [RXF_ENTRY_W-1:0] o_rd_data
);

    logic [RXF_ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: stores {ferr, perr, data} per character and presents the oldest entry
// first-word-fall-through, with occupancy flags and a sticky overflow indicator.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH    = 16,
    parameter  int unsigned AF_LEVEL = 12,
    localparam int unsigned AW       = clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   wr_en,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_perr,
    input  logic                   wr_ferr,
    input  logic                   rd_en,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   rd_perr,
    output logic                   rd_ferr,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic [CW-1:0]          count,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   r_overflow;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic                   w_ovf_set;
    logic [RXF_ENTRY_W-1:0] w_wr_entry;
    logic [RXF_ENTRY_W-1:0] w_rd_entry;

    // Flags come straight from the registered count, so wr_en/rd_en never reach them.
    assign w_empty = (r_count == CW'(0));
    assign w_full  = (r_count == CW'(DEPTH));

    // A pop in the same cycle frees the slot, so a write at full is still accepted.
    assign w_wr_ok   = wr_en & (~w_full | rd_en);
    assign w_rd_ok   = rd_en & ~w_empty;
    assign w_ovf_set = wr_en & w_full & ~rd_en;

    always_comb begin
        w_wr_entry                                   = '0;
        w_wr_entry[RXF_DATA_LSB +: UART_DATA_W]      = wr_data;
        w_wr_entry[RXF_PERR_BIT]                     = wr_perr;
        w_wr_entry[RXF_FERR_BIT]                     = wr_ferr;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - CW'(1);
            end
            // A dropped write outranks a same-cycle clear so the loss is never missed.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk     (CLK),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_entry)
    );

    assign rd_data     = w_rd_entry[RXF_DATA_LSB +: UART_DATA_W];
    assign rd_perr     = w_rd_entry[RXF_PERR_BIT];
    assign rd_ferr     = w_rd_entry[RXF_FERR_BIT];
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= CW'(AF_LEVEL));
    assign count       = r_count;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand-written full/wrap/overflow sequences,
// and random traffic checked against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFL   = 12;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_perr = 1'b0;
    logic       wr_ferr = 1'b0;
    logic       rd_en = 1'b0;
    logic       clr_overflow = 1'b0;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_ferr;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;

    uart_rx_fifo #(.DEPTH(DEPTH), .AF_LEVEL(AFL)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_perr      (wr_perr),
        .wr_ferr      (wr_ferr),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_perr      (rd_perr),
        .rd_ferr      (rd_ferr),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        logic        rd;
        logic        clr;
        logic        rst;
        int unsigned ecnt;
        logic        eovf;
        logic        ehv;
        logic [9:0]  ehead;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: FIFO contents as a queue of {ferr, perr, data} plus the sticky flag.
    logic [9:0] mq[$];
    logic       m_ovf = 1'b0;

    function automatic vec_t mk(input logic wr, input logic [7:0] d, input logic pe, input logic fe,
                                input logic rd, input logic clr, input logic rst,
                                input int unsigned ecnt, input logic eovf, input logic ehv,
                                input logic [9:0] ehead);
        vec_t v;
        v.wr = wr; v.d = d; v.pe = pe; v.fe = fe; v.rd = rd; v.clr = clr; v.rst = rst;
        v.ecnt = ecnt; v.eovf = eovf; v.ehv = ehv; v.ehead = ehead;
        return v;
    endfunction

    task automatic model_update(input logic wr, input logic [7:0] d, input logic pe, input logic fe,
                                input logic rd, input logic clr, input logic rst);
        int  sz;
        bit  was_full;
        if (rst) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            sz = mq.size();
            was_full = (sz == DEPTH);
            if (wr && was_full && !rd) m_ovf = 1'b1;
            else if (clr)              m_ovf = 1'b0;
            if (rd && sz > 0) void'(mq.pop_front());
            if (wr && (!was_full || rd)) mq.push_back({fe, pe, d});
        end
    endtask

    // Apply one cycle of inputs, advance the model, then settle past the edge for sampling.
    task automatic step(input logic wr, input logic [7:0] d, input logic pe, input logic fe,
                        input logic rd, input logic clr, input logic rst);
        wr_en = wr; wr_data = d; wr_perr = pe; wr_ferr = fe;
        rd_en = rd; clr_overflow = clr; RESET = rst;
        @(posedge CLK);
        model_update(wr, d, pe, fe, rd, clr, rst);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0; RESET = 1'b0;
    endtask

    task automatic check(input string name, input int unsigned ecnt, input logic eovf,
                         input logic ehv, input logic [9:0] ehead);
        logic [8:0] act;
        logic [8:0] exp;
        bit         bad;
        act = {count, empty, full, almost_full, overflow};
        exp = {5'(ecnt), ecnt == 0, ecnt == DEPTH, ecnt >= AFL, eovf};
        bad = (act !== exp);
        if (ehv && ({rd_ferr, rd_perr, rd_data} !== ehead)) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s @%0t: got cnt=%0d e=%b f=%b af=%b ovf=%b head=%h, want cnt=%0d ovf=%b head=%h(valid=%b)",
                     name, $time, count, empty, full, almost_full, overflow,
                     {rd_ferr, rd_perr, rd_data}, ecnt, eovf, ehead, ehv);
        end
    endtask

    task automatic check_model(input string name);
        check(name, mq.size(), m_ovf, mq.size() > 0, (mq.size() > 0) ? mq[0] : 10'h000);
    endtask

    function automatic logic [9:0] wrap_item(input int k);
        return (k < 16) ? 10'(8'h20 + k) : 10'(8'h80 + (k - 16));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        @(posedge CLK);
        #1;

        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 10'h000));
        tbl.push_back(mk(1, 8'h41, 0, 0, 0, 0, 0, 1, 0, 1, 10'h041));
        tbl.push_back(mk(1, 8'h42, 0, 0, 0, 0, 0, 2, 0, 1, 10'h041));
        tbl.push_back(mk(1, 8'h43, 0, 0, 0, 0, 0, 3, 0, 1, 10'h041));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 2, 0, 1, 10'h042));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 1, 10'h043));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000));
        tbl.push_back(mk(1, 8'h55, 1, 0, 0, 0, 0, 1, 0, 1, 10'h155));
        tbl.push_back(mk(1, 8'hAA, 0, 1, 0, 0, 0, 2, 0, 1, 10'h155));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 1, 0, 1, 10'h2AA));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000));
        tbl.push_back(mk(1, 8'h77, 0, 0, 1, 0, 0, 1, 0, 1, 10'h077));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 10'h000));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(1, 8'(i), 0, 0, 0, 0, 0, i, 0, 1, 10'h001));
        tbl.push_back(mk(1, 8'h99, 0, 0, 0, 0, 1, 0, 0, 0, 10'h000));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].pe, tbl[i].fe, tbl[i].rd, tbl[i].clr, tbl[i].rst);
            check($sformatf("tbl[%0d]", i), tbl[i].ecnt, tbl[i].eovf, tbl[i].ehv, tbl[i].ehead);
        end

        // Fill to full, watching almost_full cross at 12, then overflow on the 17th write.
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(8'h20 + i), 0, 0, 0, 0, 0);
            check("fill", i + 1, 0, 1, 10'h020);
        end
        step(1, 8'h11, 0, 0, 0, 0, 0);
        check("ovf_set", 16, 1, 1, 10'h020);
        step(1, 8'h12, 0, 0, 0, 1, 0);
        check("ovf_set_beats_clr", 16, 1, 1, 10'h020);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 0, 0, 1, 0, 0);
            check("drain", 15 - i, 1, i < 15, 10'(8'h21 + i));
        end
        step(0, 8'h00, 0, 0, 0, 1, 0);
        check("ovf_clr", 0, 0, 0, 10'h000);

        // Simultaneous write/pop at full across pointer wrap.
        for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 0, 0, 0);
        check("refill", 16, 0, 1, 10'h020);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h80 + i), 0, 0, 1, 0, 0);
            check("full_wr_rd", 16, 0, 1, wrap_item(i + 1));
        end
        for (int j = 0; j < 16; j++) begin
            step(0, 8'h00, 0, 0, 1, 0, 0);
            check("wrap_drain", 15 - j, 0, j < 15, wrap_item(21 + j));
        end

        // Randomized traffic: a write-heavy phase to hit full, then a read-heavy phase.
        for (int i = 0; i < 500; i++) begin
            logic wr;
            logic rd;
            logic clr;
            logic rst;
            wr  = (i < 250) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rd  = (i < 250) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            clr = ($urandom_range(15) == 0);
            rst = ($urandom_range(99) == 0);
            step(wr, 8'($urandom), 1'($urandom), 1'($urandom), rd, clr, rst);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
